// File: rtl/mdu_ctrl_pkg.sv
// Shared definitions for the multiply/divide unit: MD operation codes,
// the decoder's funct codes, controller states and small op classifiers.
package mdu_ctrl_pkg;

    // MD operation codes carried on the op port from the decoder
    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MFHI  = 4'd5,
        MD_MFLO  = 4'd6,
        MD_MTHI  = 4'd7,
        MD_MTLO  = 4'd8
    } md_op_e;

    // R-type funct codes the decoder maps onto md_op_e / start / d_md_use
    localparam logic [5:0] FUNCT_MFHI  = 6'h10;
    localparam logic [5:0] FUNCT_MTHI  = 6'h11;
    localparam logic [5:0] FUNCT_MFLO  = 6'h12;
    localparam logic [5:0] FUNCT_MTLO  = 6'h13;
    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_DIV   = 6'h1A;
    localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

    // Controller states: waiting for work, or counting down a long op
    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } mdu_state_e;

    // True for the ops that occupy the unit for a multi-cycle busy period
    function automatic logic is_calc_op(input logic [3:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) ||
               (op == MD_DIV)  || (op == MD_DIVU);
    endfunction

    // True for the divide class, which uses the longer busy period
    function automatic logic is_div_op(input logic [3:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/mdu_ctrl_md_arith.sv
// Combinational multiply/divide datapath. Produces the full {hi, lo} result
// for a MULT/MULTU/DIV/DIVU; a divide by zero, or any other op, returns the
// current hi/lo unchanged so the controller can always load the result.
module md_arith
    import mdu_ctrl_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    input  logic [31:0] hi,
    input  logic [31:0] lo,
    output logic [63:0] res
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] div_u;
    logic [31:0] quo_u;
    logic [31:0] rem_u;
    logic [31:0] abs_rs;
    logic [31:0] abs_rt;
    logic [31:0] abs_div;
    logic [31:0] mag_q;
    logic [31:0] mag_r;
    logic [31:0] quo_s;
    logic [31:0] rem_s;
    logic        rt_zero;

    // Products: sign-extended operands give the signed product in 64 bits
    always_comb begin
        prod_s = {{32{rs[31]}}, rs} * {{32{rt[31]}}, rt};
        prod_u = {32'd0, rs} * {32'd0, rt};
    end

    // Unsigned divide; a zero divisor is replaced so the divider never sees 0
    always_comb begin
        rt_zero = (rt == 32'd0);
        div_u   = rt_zero ? 32'd1 : rt;
        quo_u   = rs / div_u;
        rem_u   = rs % div_u;
    end

    // Signed divide on magnitudes: quotient truncates toward zero, remainder
    // follows the dividend's sign; 0x80000000 / -1 falls out as 0x80000000
    always_comb begin
        abs_rs  = rs[31] ? (~rs + 32'd1) : rs;
        abs_rt  = rt[31] ? (~rt + 32'd1) : rt;
        abs_div = rt_zero ? 32'd1 : abs_rt;
        mag_q   = abs_rs / abs_div;
        mag_r   = abs_rs % abs_div;
        quo_s   = (rs[31] ^ rt[31]) ? (~mag_q + 32'd1) : mag_q;
        rem_s   = rs[31] ? (~mag_r + 32'd1) : mag_r;
    end

    // Select the result by op; divide by zero holds the current hi/lo
    always_comb begin
        res = {hi, lo};
        case (op)
            MD_MULT:  res = prod_s;
            MD_MULTU: res = prod_u;
            MD_DIV:   res = rt_zero ? {hi, lo} : {rem_s, quo_s};
            MD_DIVU:  res = rt_zero ? {hi, lo} : {rem_u, quo_u};
            default:  res = {hi, lo};
        endcase
    end

endmodule

// File: rtl/mdu_ctrl.sv
// Multiply/divide controller for the E stage. Owns HI/LO, computes a
// result at the start edge, holds it pending for the busy period, then
// commits it. Requests a stall while a D-stage MD op would see stale HI/LO.
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        d_md_use,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] rd_data
);

    localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

    mdu_state_e  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] pend_hi_q, pend_hi_d;
    logic [31:0] pend_lo_q, pend_lo_d;
    logic [63:0] arith_res;
    logic        start_calc;

    md_arith u_arith (
        .op  (op),
        .rs  (rs_val),
        .rt  (rt_val),
        .hi  (hi_q),
        .lo  (lo_q),
        .res (arith_res)
    );

    assign start_calc = start & is_calc_op(op);

    // State, counter and HI/LO registers; reset aborts any operation in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= 4'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
        end
    end

    // Next state: launch long ops or do moves in IDLE, count down in BUSY
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        case (state_q)
            S_IDLE: begin
                if (start_calc) begin
                    pend_hi_d = arith_res[63:32];
                    pend_lo_d = arith_res[31:0];
                    cnt_d     = is_div_op(op) ? DIV_CNT : MULT_CNT;
                    state_d   = S_BUSY;
                end else if (start && (op == MD_MTHI)) begin
                    hi_d = rs_val;
                end else if (start && (op == MD_MTLO)) begin
                    lo_d = rs_val;
                end
            end
            S_BUSY: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    hi_d    = pend_hi_q;
                    lo_d    = pend_lo_q;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Move-from result for the E-stage result mux
    always_comb begin
        rd_data = 32'd0;
        case (op)
            MD_MFHI: rd_data = hi_q;
            MD_MFLO: rd_data = lo_q;
            default: rd_data = 32'd0;
        endcase
    end

    assign busy  = (state_q == S_BUSY);
    assign stall = d_md_use & (busy | start_calc);
    assign hi    = hi_q;
    assign lo    = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed cases with literal results,
// then randomized traffic compared every cycle against a behavioural model.
module tb_mdu_ctrl;

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        d_md_use;
    logic        busy;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] rd_data;

    int checks   = 0;
    int failures = 0;
    bit check_en = 1'b0;

    logic [31:0] m_hi      = 32'd0;
    logic [31:0] m_lo      = 32'd0;
    logic [31:0] m_pend_hi = 32'd0;
    logic [31:0] m_pend_lo = 32'd0;
    int          m_left    = 0;

    always #5 clk = ~clk;

    mdu_ctrl #(
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .rs_val   (rs_val),
        .rt_val   (rt_val),
        .d_md_use (d_md_use),
        .busy     (busy),
        .stall    (stall),
        .hi       (hi),
        .lo       (lo),
        .rd_data  (rd_data)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Architectural result of a long op, from plain 64-bit arithmetic
    function automatic logic [63:0] modelResult(input logic [3:0] o, input logic [31:0] a,
                                                input logic [31:0] b, input logic [31:0] h,
                                                input logic [31:0] l);
        longint          sa;
        longint          sb;
        longint          q;
        longint          r;
        longint unsigned ua;
        longint unsigned ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (o)
            OP_MULT:  return 64'(sa * sb);
            OP_MULTU: return 64'(ua * ub);
            OP_DIV: begin
                if (b == 32'd0) return {h, l};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            OP_DIVU: begin
                if (b == 32'd0) return {h, l};
                return {a % b, a / b};
            end
            default: return {h, l};
        endcase
    endfunction

    function automatic bit isCalc(input logic [3:0] o);
        return (o >= OP_MULT) && (o <= OP_DIVU);
    endfunction

    // Model advance at each active edge
    always @(posedge clk) begin
        logic [63:0] r;
        if (reset) begin
            m_hi = 0; m_lo = 0; m_pend_hi = 0; m_pend_lo = 0; m_left = 0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_hi = m_pend_hi;
                m_lo = m_pend_lo;
            end
        end else if (start) begin
            if (isCalc(op)) begin
                r = modelResult(op, rs_val, rt_val, m_hi, m_lo);
                m_pend_hi = r[63:32];
                m_pend_lo = r[31:0];
                m_left = (op == OP_DIV || op == OP_DIVU) ? 10 : 5;
            end else if (op == OP_MTHI) begin
                m_hi = rs_val;
            end else if (op == OP_MTLO) begin
                m_lo = rs_val;
            end
        end
    end

    // Compare every output against the model mid-cycle
    always @(negedge clk) begin
        logic exp_busy;
        logic exp_stall;
        logic [31:0] exp_rd;
        if (check_en) begin
            exp_busy  = (m_left > 0);
            exp_stall = d_md_use && (exp_busy || (start && isCalc(op)));
            exp_rd    = (op == OP_MFHI) ? m_hi : (op == OP_MFLO) ? m_lo : 32'd0;
            checkOutput("busy", 32'(busy), 32'(exp_busy));
            checkOutput("stall", 32'(stall), 32'(exp_stall));
            checkOutput("hi", hi, m_hi);
            checkOutput("lo", lo, m_lo);
            checkOutput("rd_data", rd_data, exp_rd);
            checkOutput("start_while_busy", 32'(start && exp_busy), 32'd0);
        end
    end

    task automatic applyStimulus(input logic st, input logic [3:0] o, input logic [31:0] a,
                                 input logic [31:0] b, input logic use_d, input logic rst);
        start    = st;
        op       = o;
        rs_val   = a;
        rt_val   = b;
        d_md_use = use_d;
        reset    = rst;
        @(posedge clk);
        #1;
    endtask

    // Launch one long op, count its busy cycles (bounded), check the length
    task automatic runCalc(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                           input int exp_cycles);
        int cycles;
        applyStimulus(1'b1, o, a, b, 1'b1, 1'b0);
        cycles = 0;
        for (int i = 0; i < 40 && busy; i++) begin
            cycles++;
            applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 1'b0);
        end
        checkOutput("busy_len", 32'(cycles), 32'(exp_cycles));
    endtask

    function automatic logic [31:0] pickOperand();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [63:0] pin;
        start = 0; op = 0; rs_val = 0; rt_val = 0; d_md_use = 0; reset = 1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_en = 1'b1;
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_hi", hi, 32'd0);
        checkOutput("reset_lo", lo, 32'd0);

        pin = modelResult(OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'd0, 32'd0);
        checkOutput("model_div_neg_lo", pin[31:0], 32'hFFFF_FFFD);
        checkOutput("model_div_neg_hi", pin[63:32], 32'hFFFF_FFFF);

        runCalc(OP_MULT, 32'hFFFF_FFFD, 32'd5, 5);
        checkOutput("mult_hi", hi, 32'hFFFF_FFFF);
        checkOutput("mult_lo", lo, 32'hFFFF_FFF1);

        runCalc(OP_DIVU, 32'd7, 32'd2, 10);
        checkOutput("divu_lo", lo, 32'd3);
        checkOutput("divu_hi", hi, 32'd1);

        runCalc(OP_DIV, 32'hFFFF_FFF9, 32'd2, 10);
        checkOutput("div_lo", lo, 32'hFFFF_FFFD);
        checkOutput("div_hi", hi, 32'hFFFF_FFFF);

        applyStimulus(1'b1, OP_MTHI, 32'h11, 32'd0, 1'b0, 1'b0);
        applyStimulus(1'b1, OP_MTLO, 32'h22, 32'd0, 1'b0, 1'b0);
        checkOutput("mt_busy", 32'(busy), 32'd0);
        runCalc(OP_DIV, 32'd5, 32'd0, 10);
        checkOutput("div0_hi", hi, 32'h11);
        checkOutput("div0_lo", lo, 32'h22);

        runCalc(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10);
        checkOutput("divovf_lo", lo, 32'h8000_0000);
        checkOutput("divovf_hi", hi, 32'd0);

        applyStimulus(1'b1, OP_MTHI, 32'hDEAD_BEEF, 32'd0, 1'b0, 1'b0);
        start = 1'b1; op = OP_MFHI; rs_val = 0; rt_val = 0; d_md_use = 1'b0;
        #1;
        checkOutput("mfhi_rd", rd_data, 32'hDEAD_BEEF);
        checkOutput("mfhi_hi", hi, 32'hDEAD_BEEF);
        checkOutput("mfhi_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;

        applyStimulus(1'b1, OP_MULTU, 32'd3, 32'd4, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b1);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_hi", hi, 32'd0);
        checkOutput("abort_lo", lo, 32'd0);
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        checkOutput("abort_hi_late", hi, 32'd0);
        checkOutput("abort_lo_late", lo, 32'd0);

        for (int i = 0; i < 600; i++) begin
            logic st;
            st = (m_left == 0) && ($urandom_range(0, 1) == 1);
            applyStimulus(st, 4'($urandom_range(0, 10)), pickOperand(), pickOperand(),
                          1'($urandom_range(0, 1)), ($urandom_range(0, 79) == 0));
        end
        for (int i = 0; i < 20; i++) applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0);

        check_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
